// File: rtl/sprite_dma_sched_pkg.sv
// Shared constants and helpers for the sprite DMA scheduler.
package sprite_dma_sched_pkg;

  // Slot counter width, sized for the largest legal per-sprite slot count (15).
  localparam int SlotCntW = 4;

  // Index width that never collapses below one bit, even for a single requester.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit priority encoder with an any-set flag.
module prio_enc
  import sprite_dma_sched_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0]           mask_i,
  output logic [idxWidth(N)-1:0] idx_o,
  output logic                   any_o
);

  localparam int IW = idxWidth(N);

  // Scan from the top down so the lowest set bit is the final value written.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o = IW'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_dma_sched.sv
// Sprite DMA scheduler: hands out fixed-length ROM read slots to pending
// sprites in ascending index order during the horizontal DMA window.
// The overrun pulse is registered, so a retrigger seen at sx == HACTIVE shows
// on the following cycle, and a window close is detected one pixel early so
// that no grant is ever issued on the sx == DMA_END cycle itself; the pulse
// then lands exactly on sx == DMA_END.
module sprite_dma_sched
  import sprite_dma_sched_pkg::*;
#(
  parameter int NSPR    = 5,
  parameter int SLOT    = 2,
  parameter int ADDRW   = 9,
  parameter int CORDW   = 12,
  parameter int HACTIVE = 1280,
  parameter int DMA_END = 1340
) (
  input  logic                      clk_pix,
  input  logic                      rst,
  input  logic [CORDW-1:0]          sx,
  input  logic [NSPR-1:0]           req,
  input  logic [NSPR*ADDRW-1:0]     spr_addr,
  output logic [NSPR-1:0]           dma_avail,
  output logic [ADDRW-1:0]          rom_addr,
  output logic                      data_valid,
  output logic [idxWidth(NSPR)-1:0] data_owner,
  output logic                      busy,
  output logic                      overrun
);

  localparam int IW = idxWidth(NSPR);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [NSPR-1:0]       pending_q, pending_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [SlotCntW-1:0]   slot_q, slot_d;
  logic                  overrun_q, overrun_d;
  logic                  dataValid_q;
  logic [IW-1:0]         dataOwner_q;

  logic                  trigger;
  logic                  closeNext;
  logic                  slotDone;
  logic [NSPR-1:0]       curBit;
  logic [NSPR-1:0]       encMask;
  logic [IW-1:0]         encIdx;
  logic                  encAny;

  assign trigger   = (sx == CORDW'(HACTIVE));
  assign closeNext = (sx == CORDW'(DMA_END - 1));
  assign slotDone  = (slot_q == SlotCntW'(SLOT - 1));
  assign curBit    = NSPR'(1) << idx_q;

  // The single encoder sees the fresh request on a trigger, otherwise the
  // pending mask with the sprite currently being served removed.
  assign encMask = trigger ? req : (pending_q & ~curBit);

  prio_enc #(
    .N (NSPR)
  ) u_prio_enc (
    .mask_i (encMask),
    .idx_o  (encIdx),
    .any_o  (encAny)
  );

  // Next-state logic: trigger restarts the schedule, slots advance back to back,
  // and the window close cancels whatever is still pending.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    slot_d    = slot_q;
    overrun_d = 1'b0;

    if (trigger) begin
      overrun_d = (state_q == GRANT);
      slot_d    = '0;
      if (encAny) begin
        state_d   = GRANT;
        pending_d = req;
        idx_d     = encIdx;
      end else begin
        state_d   = IDLE;
        pending_d = '0;
        idx_d     = '0;
      end
    end else if (state_q == GRANT) begin
      slot_d = slot_q + SlotCntW'(1);
      if (slotDone) begin
        pending_d = encMask;
        slot_d    = '0;
        if (encAny) begin
          idx_d = encIdx;
        end else begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      if (closeNext && (state_d == GRANT)) begin
        overrun_d = 1'b1;
        state_d   = IDLE;
        pending_d = '0;
        idx_d     = '0;
        slot_d    = '0;
      end
    end
  end

  // Scheduler state and the one-cycle-delayed ROM data tags.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      idx_q       <= '0;
      slot_q      <= '0;
      overrun_q   <= 1'b0;
      dataValid_q <= 1'b0;
      dataOwner_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      idx_q       <= idx_d;
      slot_q      <= slot_d;
      overrun_q   <= overrun_d;
      dataValid_q <= (state_q == GRANT);
      dataOwner_q <= idx_q;
    end
  end

  // Grant decode and live ROM address mux straight off the state registers.
  always_comb begin
    dma_avail = '0;
    rom_addr  = '0;
    if (state_q == GRANT) begin
      for (int i = 0; i < NSPR; i++) begin
        if (idx_q == IW'(i)) begin
          dma_avail[i] = 1'b1;
          rom_addr     = spr_addr[i*ADDRW +: ADDRW];
        end
      end
    end
  end

  assign busy       = (state_q == GRANT);
  assign data_valid = dataValid_q;
  assign data_owner = dataOwner_q;
  assign overrun    = overrun_q;

endmodule
